pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage sitting directly upstream of the control unit. Holds PC and IR, computes the next PC from the control unit's mode selects (`mode12K`, `modeAddZA`), and runs a req/ack read on program memory. Fetched words land in IR, or in a data register for Z-addressed program-memory reads. IR feeds the control unit's decode; the Z flag path is not touched here.

## Interface
Parameters:
- `P_AW`, 16: PC / program-memory word-address width.
- `P_RESET_PC`, 16'h0000: PC value after reset.

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  one clock; reset is asynchronous and active-high.
- `i_loadPC`  in  1  load PC with adder result this cycle.
- `i_mode12K`  in  2  adder B operand select.
- `i_modeAddZA`  in  2  adder A operand select.
- `i_modePCZ`  in  1  fetch address source: 0 = PC (instruction), 1 = Z (data).
- `i_K`  in  16  immediate from control unit.
- `i_Z`  in  16  Z pointer from register file.
- `i_fetch`  in  1  single-cycle fetch request.
- `o_busy`  out  1  a fetch is outstanding.
- `o_IR`  out  16  instruction register.
- `o_ir_valid`  out  1  one-cycle pulse: IR just updated.
- `o_pm_dout`  out  16  last Z-addressed program-memory word.
- `o_dout_valid`  out  1  one-cycle pulse: `o_pm_dout` just updated.
- `o_PC`  out  P_AW  current PC.
- `o_pm_req`  out  1  program-memory read request.
- `o_pm_addr`  out  P_AW  program-memory word address.
- `i_pm_ack`  in  1  memory has valid data this cycle.
- `i_pm_data`  in  16  memory read data.

## Operation
- Adder: next = A + B, truncated to P_AW; wrap-around modulo 2^P_AW, no flags.
- A (`i_modeAddZA`): 00 = PC, 01 = 0, 10 = `i_Z`, 11 = PC (reserved).
- B (`i_mode12K`): 00 = +1, 01 = `i_K`, 10 = sign-extend `i_K[11:0]`, 11 = +2.
- `i_loadPC`=1: PC <= next at the edge, in any fetch state.
- FSM states:
  - IDLE:
    - On `i_fetch`, latch the address register: `i_modePCZ`=0 uses PC, 1 uses `i_Z`.
    - Latch `i_modePCZ` as the destination select, then go to REQ.
    - An instruction fetch also does PC <= PC+1 at the same edge, unless `i_loadPC` is high; `i_loadPC` wins.
  - REQ:
    - `o_pm_req`=1, `o_pm_addr` = address register.
    - On `i_pm_ack`: capture `i_pm_data` into IR or `o_pm_dout` per the destination select, then go to DONE.
  - DONE:
    - Pulse `o_ir_valid` or `o_dout_valid`, then go to IDLE.
- `i_fetch` outside IDLE is ignored; no queueing.
- `o_busy` = state ≠ IDLE.
- `i_pm_ack` outside REQ is ignored.
- Reset at any point, including mid-REQ: all state clears immediately (asynchronous), `o_pm_req` drops the same instant, and no valid pulse follows.

## Timing
- Reset values:
  - PC = P_RESET_PC.
  - IR = 16'h0000; `o_pm_dout` = 16'h0000.
  - `o_pm_addr` = 0.
  - `o_pm_req`, `o_busy`, `o_ir_valid`, `o_dout_valid` = 0.
  - State = IDLE.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- Fetch latency with zero-wait memory (ack in the first REQ cycle):
  - `i_fetch` sampled at edge 0.
  - REQ is visible in cycle 1; ack is sampled at edge 1.
  - Valid pulse and new IR are visible in cycle 2.
  - IDLE again in cycle 3.
  - Minimum issue interval: 3 cycles.
- Each wait cycle (no ack) adds one cycle; `o_pm_addr` stays stable while `o_pm_req`=1.
- PC increment is visible the cycle after the accepting edge, i.e. before the data returns.

## Structure
- Shared package `cu_pkg` holds:
  - Mode encodings: `MODE12K_ONE/K16/K12/TWO`, `MODEAZ_PC/ZERO/Z`.
  - Fetch-state typedef.
  - `P_RESET_PC` default.
  - The control unit uses the same encodings.
- Natural sub-module: `pc_addr_adder`, the combinational operand muxes plus adder. Reused for PC update only; fetch addresses never pass through it.

## Test plan
- Reset mid-REQ:
  - Fetch from PC=0, hold ack low, assert `i_reset` between edges.
  - `o_pm_req` falls without waiting for an edge; PC=0, IR=0; no valid pulse.
- Sequential fetch:
  - PC=0x0010, `i_fetch`, ack next cycle with data 0xC005.
  - `o_pm_addr`=0x0010; IR=0xC005 with `o_ir_valid` in cycle 2; PC=0x0011.
- Relative jump with sign extension:
  - PC=0x0011, `i_loadPC`, mode12K=10, modeAddZA=00, K=0x0FFE.
  - PC=0x000F.
- Wrap and indirect jump:
  - PC=0xFFFF, loadPC with +1 gives PC=0x0000.
  - Then modeAddZA=10, mode12K=01, K=0, Z=0x1234 gives PC=0x1234.
- Data fetch with waits:
  - `i_modePCZ`=1, Z=0x0200, ack after 3 wait cycles, data 0xBEEF.
  - `o_pm_dout`=0xBEEF, `o_dout_valid` pulse; IR and PC unchanged; `i_fetch` during busy ignored.
- Load PC during an instruction fetch:
  - Simultaneous `i_fetch` and `i_loadPC` (K16 path, K=0x0100) at PC=0x0020.
  - Fetch address 0x0020; PC=0x0120, not 0x0021.

Source files
------------

// File: rtl/cu_pkg.sv
// Encodings shared by the fetch stage and the control unit: adder operand selects,
// fetch FSM states and the default reset PC. Combinational only; no backpressure.
package cu_pkg;

  localparam logic [1:0] MODE12K_ONE = 2'b00;
  localparam logic [1:0] MODE12K_K16 = 2'b01;
  localparam logic [1:0] MODE12K_K12 = 2'b10;
  localparam logic [1:0] MODE12K_TWO = 2'b11;

  localparam logic [1:0] MODEAZ_PC   = 2'b00;
  localparam logic [1:0] MODEAZ_ZERO = 2'b01;
  localparam logic [1:0] MODEAZ_Z    = 2'b10;

  localparam logic [15:0] P_RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_REQ  = 2'b01,
    FS_DONE = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Program-memory read port: req/addr held until ack; one data word per ack.
// No buffering; the master holds the request until the slave acks.
interface pc_fetch_unit_if #(
  parameter int P_AW = 16
);
  logic            pm_req;
  logic [P_AW-1:0] pm_addr;
  logic            pm_ack;
  logic [15:0]     pm_data;

  modport master (
    output pm_req,
    output pm_addr,
    input  pm_ack,
    input  pm_data
  );

  modport slave (
    input  pm_req,
    input  pm_addr,
    output pm_ack,
    output pm_data
  );
endinterface

// File: rtl/pc_fetch_unit_adder.sv
// Next-PC adder: operand muxes plus a wrap-around add, purely combinational.
// Zero latency; no handshake, the caller decides when to load the result.
module pc_addr_adder
  import cu_pkg::*;
#(
  parameter int P_AW = 16
) (
  input  logic [P_AW-1:0] pc,
  input  logic [1:0]      mode_12k,
  input  logic [1:0]      mode_add_za,
  input  logic [15:0]     k,
  input  logic [15:0]     z,
  output logic [P_AW-1:0] next_pc
);

  logic [P_AW-1:0] op_a;
  logic [P_AW-1:0] op_b;

  always_comb begin
    op_a = pc;
    case (mode_add_za)
      MODEAZ_ZERO: op_a = '0;
      MODEAZ_Z:    op_a = P_AW'(z);
      default:     op_a = pc;  // 2'b11 is reserved and behaves like PC
    endcase
  end

  always_comb begin
    op_b = P_AW'(1);
    case (mode_12k)
      MODE12K_ONE: op_b = P_AW'(1);
      MODE12K_K16: op_b = P_AW'(k);
      MODE12K_K12: op_b = P_AW'($signed(k[11:0]));
      MODE12K_TWO: op_b = P_AW'(2);
      default:     op_b = P_AW'(1);
    endcase
  end

  assign next_pc = op_a + op_b;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC/IR fetch stage: one outstanding program-memory read, 3-cycle minimum issue interval.
// Fetch requests while busy are dropped; memory wait states stretch the REQ state.
module pc_fetch_unit
  import cu_pkg::*;
#(
  parameter int              P_AW       = 16,
  parameter logic [P_AW-1:0] P_RESET_PC = P_AW'(P_RESET_PC_DEF)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_loadPC,
  input  logic [1:0]        i_mode12K,
  input  logic [1:0]        i_modeAddZA,
  input  logic              i_modePCZ,
  input  logic [15:0]       i_K,
  input  logic [15:0]       i_Z,
  input  logic              i_fetch,
  output logic              o_busy,
  output logic [15:0]       o_IR,
  output logic              o_ir_valid,
  output logic [15:0]       o_pm_dout,
  output logic              o_dout_valid,
  output logic [P_AW-1:0]   o_PC,
  pc_fetch_unit_if.master   pm
);

  fetch_state_t    state;
  logic [P_AW-1:0] pc;
  logic [P_AW-1:0] addr;
  logic            dest_data;
  logic            req;
  logic            busy;
  logic            ir_valid;
  logic            dout_valid;
  logic [15:0]     ir;
  logic [15:0]     pm_dout;
  logic [P_AW-1:0] next_pc;
  logic            inst_fetch_accept;

  pc_addr_adder #(.P_AW(P_AW)) u_adder (
    .pc          (pc),
    .mode_12k    (i_mode12K),
    .mode_add_za (i_modeAddZA),
    .k           (i_K),
    .z           (i_Z),
    .next_pc     (next_pc)
  );

  assign inst_fetch_accept = (state == FS_IDLE) && i_fetch && !i_modePCZ;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= FS_IDLE;
      pc         <= P_RESET_PC;
      addr       <= '0;
      dest_data  <= 1'b0;
      req        <= 1'b0;
      busy       <= 1'b0;
      ir_valid   <= 1'b0;
      dout_valid <= 1'b0;
      ir         <= 16'h0000;
      pm_dout    <= 16'h0000;
    end else begin
      ir_valid   <= 1'b0;
      dout_valid <= 1'b0;

      // An explicit PC load overrides the post-fetch increment.
      if (i_loadPC) begin
        pc <= next_pc;
      end else if (inst_fetch_accept) begin
        pc <= pc + P_AW'(1);
      end

      case (state)
        FS_IDLE: begin
          if (i_fetch) begin
            addr      <= i_modePCZ ? P_AW'(i_Z) : pc;
            dest_data <= i_modePCZ;
            req       <= 1'b1;
            busy      <= 1'b1;
            state     <= FS_REQ;
          end
        end
        FS_REQ: begin
          if (pm.pm_ack) begin
            if (dest_data) pm_dout <= pm.pm_data;
            else           ir      <= pm.pm_data;
            dout_valid <= dest_data;
            ir_valid   <= !dest_data;
            req        <= 1'b0;
            state      <= FS_DONE;
          end
        end
        FS_DONE: begin
          busy  <= 1'b0;
          state <= FS_IDLE;
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          state <= FS_IDLE;
        end
      endcase
    end
  end

  assign pm.pm_req    = req;
  assign pm.pm_addr   = addr;
  assign o_busy       = busy;
  assign o_IR         = ir;
  assign o_ir_valid   = ir_valid;
  assign o_pm_dout    = pm_dout;
  assign o_dout_valid = dout_valid;
  assign o_PC         = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs driven and outputs sampled on the falling edge.
module tb_pc_fetch_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_pc = 1'b0;
  logic [1:0]  mode_12k = 2'b00;
  logic [1:0]  mode_az = 2'b00;
  logic        mode_pcz = 1'b0;
  logic [15:0] k = 16'h0000;
  logic [15:0] z = 16'h0000;
  logic        fetch = 1'b0;
  logic        busy;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] pm_dout;
  logic        dout_valid;
  logic [15:0] pc;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit_if #(.P_AW(16)) pm ();

  pc_fetch_unit #(.P_AW(16), .P_RESET_PC(16'h0000)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_loadPC     (load_pc),
    .i_mode12K    (mode_12k),
    .i_modeAddZA  (mode_az),
    .i_modePCZ    (mode_pcz),
    .i_K          (k),
    .i_Z          (z),
    .i_fetch      (fetch),
    .o_busy       (busy),
    .o_IR         (ir),
    .o_ir_valid   (ir_valid),
    .o_pm_dout    (pm_dout),
    .o_dout_valid (dout_valid),
    .o_PC         (pc),
    .pm           (pm.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Loads PC through the zero + K16 adder path.
  task automatic set_pc(input logic [15:0] v);
    @(negedge clk);
    load_pc = 1'b1; mode_az = MODEAZ_ZERO; mode_12k = MODE12K_K16; k = v;
    @(negedge clk);
    load_pc = 1'b0; mode_az = MODEAZ_PC; mode_12k = MODE12K_ONE; k = 16'h0000;
    vectors++;
    if (pc !== v) begin miscompares++; $display("FAIL set_pc: pc=%h want %h", pc, v); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pm.pm_ack = 1'b0; pm.pm_data = 16'h0000;
    #2;
    vectors++;
    if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: %h want 0000", pc); end
    vectors++;
    if (ir !== 16'h0000 || pm_dout !== 16'h0000) begin
      miscompares++; $display("FAIL reset_regs: ir=%h dout=%h want 0000/0000", ir, pm_dout);
    end
    vectors++;
    if ({pm.pm_req, busy, ir_valid, dout_valid} !== 4'b0000 || pm.pm_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/busy/irv/dv=%b addr=%h want 0000/0000",
               {pm.pm_req, busy, ir_valid, dout_valid}, pm.pm_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pc !== 16'h0000) begin
      miscompares++; $display("FAIL reset_idle: busy=%b pc=%h want 0/0000", busy, pc);
    end
  endtask

  task automatic test_sequential_fetch;
    set_pc(16'h0010);
    @(negedge clk); fetch = 1'b1; mode_pcz = 1'b0;
    @(negedge clk); fetch = 1'b0;
    vectors++;
    if (pm.pm_req !== 1'b1 || pm.pm_addr !== 16'h0010) begin
      miscompares++; $display("FAIL seq_req: req=%b addr=%h want 1/0010", pm.pm_req, pm.pm_addr);
    end
    vectors++;
    if (pc !== 16'h0011 || ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL seq_pc_inc: pc=%h irv=%b want 0011/0", pc, ir_valid);
    end
    pm.pm_ack = 1'b1; pm.pm_data = 16'hC005;
    @(negedge clk); pm.pm_ack = 1'b0;
    vectors++;
    if (ir !== 16'hC005 || ir_valid !== 1'b1 || dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_ir: ir=%h irv=%b dv=%b want c005/1/0", ir, ir_valid, dout_valid);
    end
    vectors++;
    if (pm.pm_req !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL seq_done: req=%b busy=%b want 0/1", pm.pm_req, busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL seq_idle: busy=%b irv=%b want 0/0", busy, ir_valid);
    end
  endtask

  task automatic test_rel_jump;
    @(negedge clk);
    load_pc = 1'b1; mode_az = MODEAZ_PC; mode_12k = MODE12K_K12; k = 16'h0FFE;
    @(negedge clk);
    load_pc = 1'b0; mode_12k = MODE12K_ONE; k = 16'h0000;
    vectors++;
    if (pc !== 16'h000F) begin miscompares++; $display("FAIL rel_jump: pc=%h want 000f", pc); end
  endtask

  task automatic test_wrap_indirect;
    logic [1:0]  az_tab [3]  = '{MODEAZ_Z, MODEAZ_PC, 2'b11};
    logic [1:0]  b_tab  [3]  = '{MODE12K_K16, MODE12K_TWO, MODE12K_ONE};
    logic [15:0] exp_tab [3] = '{16'h1234, 16'h1236, 16'h1237};
    set_pc(16'hFFFF);
    @(negedge clk); load_pc = 1'b1; mode_az = MODEAZ_PC; mode_12k = MODE12K_ONE;
    @(negedge clk); load_pc = 1'b0;
    vectors++;
    if (pc !== 16'h0000) begin miscompares++; $display("FAIL wrap: pc=%h want 0000", pc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_pc = 1'b1; mode_az = az_tab[i]; mode_12k = b_tab[i]; k = 16'h0000; z = 16'h1234;
      @(negedge clk);
      load_pc = 1'b0; mode_az = MODEAZ_PC; mode_12k = MODE12K_ONE;
      vectors++;
      if (pc !== exp_tab[i]) begin
        miscompares++; $display("FAIL indirect_%0d: pc=%h want %h", i, pc, exp_tab[i]);
      end
    end
  endtask

  task automatic test_data_fetch;
    @(negedge clk); fetch = 1'b1; mode_pcz = 1'b1; z = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch = 1'b1; mode_pcz = 1'b0; z = 16'h0300;
      vectors++;
      if (pm.pm_req !== 1'b1 || pm.pm_addr !== 16'h0200 || busy !== 1'b1 || pc !== 16'h1237) begin
        miscompares++;
        $display("FAIL data_wait_%0d: req=%b addr=%h busy=%b pc=%h want 1/0200/1/1237",
                 i, pm.pm_req, pm.pm_addr, busy, pc);
      end
    end
    @(negedge clk);
    fetch = 1'b0; pm.pm_ack = 1'b1; pm.pm_data = 16'hBEEF;
    @(negedge clk); pm.pm_ack = 1'b0;
    vectors++;
    if (pm_dout !== 16'hBEEF || dout_valid !== 1'b1 || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL data_dout: dout=%h dv=%b irv=%b want beef/1/0", pm_dout, dout_valid, ir_valid);
    end
    vectors++;
    if (ir !== 16'hC005 || pc !== 16'h1237) begin
      miscompares++; $display("FAIL data_keep: ir=%h pc=%h want c005/1237", ir, pc);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      miscompares++; $display("FAIL data_idle: busy=%b dv=%b want 0/0", busy, dout_valid);
    end
    pm.pm_ack = 1'b1; pm.pm_data = 16'hDEAD;
    @(negedge clk); @(negedge clk);
    pm.pm_ack = 1'b0;
    vectors++;
    if (ir !== 16'hC005 || pm_dout !== 16'hBEEF || busy !== 1'b0 || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_ack: ir=%h dout=%h busy=%b irv=%b want c005/beef/0/0",
               ir, pm_dout, busy, ir_valid);
    end
  endtask

  task automatic test_load_during_fetch;
    set_pc(16'h0020);
    @(negedge clk);
    fetch = 1'b1; mode_pcz = 1'b0;
    load_pc = 1'b1; mode_az = MODEAZ_PC; mode_12k = MODE12K_K16; k = 16'h0100;
    @(negedge clk);
    fetch = 1'b0; load_pc = 1'b0; mode_12k = MODE12K_ONE; k = 16'h0000;
    vectors++;
    if (pm.pm_addr !== 16'h0020 || pm.pm_req !== 1'b1) begin
      miscompares++; $display("FAIL ldf_addr: addr=%h req=%b want 0020/1", pm.pm_addr, pm.pm_req);
    end
    vectors++;
    if (pc !== 16'h0120) begin miscompares++; $display("FAIL ldf_pc: pc=%h want 0120", pc); end
    pm.pm_ack = 1'b1; pm.pm_data = 16'h1111;
    @(negedge clk); pm.pm_ack = 1'b0;
    vectors++;
    if (ir !== 16'h1111 || ir_valid !== 1'b1 || pc !== 16'h0120) begin
      miscompares++;
      $display("FAIL ldf_ir: ir=%h irv=%b pc=%h want 1111/1/0120", ir, ir_valid, pc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req;
    set_pc(16'h0000);
    @(negedge clk); fetch = 1'b1; mode_pcz = 1'b0;
    @(negedge clk); fetch = 1'b0;
    vectors++;
    if (pm.pm_req !== 1'b1 || pc !== 16'h0001) begin
      miscompares++; $display("FAIL mid_pre: req=%b pc=%h want 1/0001", pm.pm_req, pc);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (pm.pm_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_req_drop: req=%b busy=%b want 0/0", pm.pm_req, busy);
    end
    vectors++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || pm.pm_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_state: pc=%h ir=%h addr=%h want 0000/0000/0000", pc, ir, pm.pm_addr);
    end
    @(negedge clk); rst = 1'b0;
    pm.pm_ack = 1'b1; pm.pm_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ir_valid !== 1'b0 || dout_valid !== 1'b0 || ir !== 16'h0000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_after_%0d: irv=%b dv=%b ir=%h busy=%b want 0/0/0000/0",
                 i, ir_valid, dout_valid, ir, busy);
      end
    end
    pm.pm_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential_fetch;
    test_rel_jump;
    test_wrap_indirect;
    test_data_fetch;
    test_load_during_fetch;
    test_reset_mid_req;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
